// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// Shift-and-add unsigned multiplier that borrows the shared execute-stage ALU
// for its additions. Operands arrive over a valid/ready request handshake, one
// ALU addition is issued per cycle while multiplier bits remain, and the low
// 32 bits of the product plus a true-overflow flag are returned over a
// valid/ready response handshake.

module alu_mul_sequencer #(
   parameter logic [3:0] ALU_ADD_CODE  = 4'b0010,
   parameter logic [3:0] ALU_IDLE_CODE = 4'b0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_prod,
   output logic        rsp_ovf,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_ctrl,
   input  logic [31:0] alu_result
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] p_q, p_d;
   logic [31:0] m_q, m_d;
   logic [31:0] q_q, q_d;
   logic        m_lost_q, m_lost_d;
   logic        ovf_q, ovf_d;

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         p_q      <= '0;
         m_q      <= '0;
         q_q      <= '0;
         m_lost_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         p_q      <= p_d;
         m_q      <= m_d;
         q_q      <= q_d;
         m_lost_q <= m_lost_d;
         ovf_q    <= ovf_d;
      end
   end

   // Next-state, datapath update and handshake/ALU drive. The ALU is only
   // driven with real operands in RUN so it sees quiet inputs otherwise.
   // Overflow is exact: an added term either carries out of bit 31 or has
   // already lost multiplicand bits off the top, both of which imply the
   // full 64-bit product reaches 2^32.
   always_comb begin
      state_d   = state_q;
      p_d       = p_q;
      m_d       = m_q;
      q_d       = q_q;
      m_lost_d  = m_lost_q;
      ovf_d     = ovf_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      alu_ctrl  = ALU_IDLE_CODE;

      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               p_d      = '0;
               m_d      = req_a;
               q_d      = req_b;
               m_lost_d = 1'b0;
               ovf_d    = 1'b0;
               if (req_b == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            alu_a    = p_q;
            alu_b    = m_q;
            alu_ctrl = ALU_ADD_CODE;
            if (q_q[0]) begin
               p_d   = alu_result;
               ovf_d = ovf_q | m_lost_q | (alu_result < p_q);
            end
            m_lost_d = m_lost_q | m_q[31];
            m_d      = {m_q[30:0], 1'b0};
            q_d      = {1'b0, q_q[31:1]};
            if (q_q[31:1] == 31'd0) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Result outputs come straight from flops so they stay glitch-free and
   // stable for as long as DONE is held.
   assign rsp_prod = p_q;
   assign rsp_ovf  = ovf_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer
// Drives directed and random multiply requests into alu_mul_sequencer with a
// behavioural ALU attached, and compares latency, ALU drive, results and
// handshake behaviour against a plain-arithmetic reference model.

module tb_alu_mul_sequencer;

   localparam logic [3:0] ADD_CODE  = 4'b0010;
   localparam logic [3:0] IDLE_CODE = 4'b0000;

   logic        clk;
   logic        rst_n;
   logic        reqValid;
   logic        reqReady;
   logic [31:0] reqA;
   logic [31:0] reqB;
   logic        rspValid;
   logic        rspReady;
   logic [31:0] rspProd;
   logic        rspOvf;
   logic [31:0] aluA;
   logic [31:0] aluB;
   logic [3:0]  aluCtrl;
   logic [31:0] aluResult;

   int errorCount;
   int checkCount;

   alu_mul_sequencer #(
      .ALU_ADD_CODE (ADD_CODE),
      .ALU_IDLE_CODE(IDLE_CODE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (reqValid),
      .req_ready (reqReady),
      .req_a     (reqA),
      .req_b     (reqB),
      .rsp_valid (rspValid),
      .rsp_ready (rspReady),
      .rsp_prod  (rspProd),
      .rsp_ovf   (rspOvf),
      .alu_a     (aluA),
      .alu_b     (aluB),
      .alu_ctrl  (aluCtrl),
      .alu_result(aluResult)
   );

   // Behavioural shared ALU: ADD when asked, AND otherwise.
   assign aluResult = (aluCtrl == ADD_CODE) ? (aluA + aluB) : (aluA & aluB);

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Number of RUN cycles: position of the multiplier's highest set bit plus one.
   function automatic int modelIterations(input logic [31:0] b);
      int n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         if (b[i]) n = i + 1;
      end
      return n;
   endfunction

   // One complete transaction: request, iteration monitoring, response held
   // for holdCycles with rsp_ready low, then the response handshake.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input int holdCycles);
      logic [63:0] fullProd;
      logic [63:0] lowMask;
      logic [31:0] expProd;
      logic        expOvf;
      int          expIter;
      int          cycles;

      fullProd = {32'd0, a} * {32'd0, b};
      expProd  = fullProd[31:0];
      expOvf   = (fullProd[63:32] != 32'd0);
      expIter  = modelIterations(b);

      @(negedge clk);
      checkOutput("req_ready in idle", {63'd0, reqReady}, 64'd1);
      reqValid = 1'b1;
      reqA     = a;
      reqB     = b;
      @(negedge clk);
      reqValid = 1'b0;
      reqA     = $urandom;
      reqB     = $urandom;

      cycles = 0;
      while (!rspValid && cycles < 40) begin
         lowMask = (64'd1 << cycles) - 64'd1;
         checkOutput("alu_ctrl in run", {60'd0, aluCtrl}, {60'd0, ADD_CODE});
         checkOutput("alu_b in run", {32'd0, aluB}, ({32'd0, a} << cycles) & 64'hFFFF_FFFF);
         checkOutput("alu_a in run", {32'd0, aluA},
                     ({32'd0, a} * ({32'd0, b} & lowMask)) & 64'hFFFF_FFFF);
         checkOutput("req_ready in run", {63'd0, reqReady}, 64'd0);
         @(negedge clk);
         cycles++;
      end
      checkOutput("latency", cycles, expIter);
      checkOutput("alu_ctrl in done", {60'd0, aluCtrl}, {60'd0, IDLE_CODE});
      checkOutput("rsp_prod", {32'd0, rspProd}, {32'd0, expProd});
      checkOutput("rsp_ovf", {63'd0, rspOvf}, {63'd0, expOvf});

      // A competing request during DONE must not be taken.
      reqValid = (holdCycles > 0);
      for (int h = 0; h < holdCycles; h++) begin
         @(negedge clk);
         checkOutput("rsp_valid held", {63'd0, rspValid}, 64'd1);
         checkOutput("rsp_prod held", {32'd0, rspProd}, {32'd0, expProd});
         checkOutput("rsp_ovf held", {63'd0, rspOvf}, {63'd0, expOvf});
         checkOutput("req_ready in done", {63'd0, reqReady}, 64'd0);
      end
      reqValid = 1'b0;

      rspReady = 1'b1;
      @(negedge clk);
      rspReady = 1'b0;
      checkOutput("rsp_valid after handshake", {63'd0, rspValid}, 64'd0);
      checkOutput("req_ready after handshake", {63'd0, reqReady}, 64'd1);
   endtask

   // Test sequence: reset state, directed cases, mid-run reset, random cases.
   initial begin
      logic [31:0] randA;
      logic [31:0] randB;

      errorCount = 0;
      checkCount = 0;
      rst_n      = 1'b0;
      reqValid   = 1'b0;
      reqA       = '0;
      reqB       = '0;
      rspReady   = 1'b0;

      #12;
      checkOutput("reset req_ready", {63'd0, reqReady}, 64'd1);
      checkOutput("reset rsp_valid", {63'd0, rspValid}, 64'd0);
      checkOutput("reset rsp_prod", {32'd0, rspProd}, 64'd0);
      checkOutput("reset alu_ctrl", {60'd0, aluCtrl}, {60'd0, IDLE_CODE});
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(32'd7, 32'd6, 0);
      applyStimulus(32'h1234_5678, 32'd0, 2);
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      applyStimulus(32'h8000_0000, 32'd2, 0);
      applyStimulus(32'h0001_0000, 32'h0000_FFFF, 0);
      applyStimulus(32'd9, 32'd1, 5);

      // Reset asserted during the third RUN cycle of a 32-iteration operation.
      @(negedge clk);
      reqValid = 1'b1;
      reqA     = 32'hFFFF_FFFF;
      reqB     = 32'hFFFF_FFFF;
      @(negedge clk);
      reqValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("pre-reset alu_ctrl", {60'd0, aluCtrl}, {60'd0, ADD_CODE});
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrun reset req_ready", {63'd0, reqReady}, 64'd1);
      checkOutput("midrun reset rsp_valid", {63'd0, rspValid}, 64'd0);
      checkOutput("midrun reset rsp_prod", {32'd0, rspProd}, 64'd0);
      checkOutput("midrun reset rsp_ovf", {63'd0, rspOvf}, 64'd0);
      checkOutput("midrun reset alu_a", {32'd0, aluA}, 64'd0);
      checkOutput("midrun reset alu_b", {32'd0, aluB}, 64'd0);
      checkOutput("midrun reset alu_ctrl", {60'd0, aluCtrl}, {60'd0, IDLE_CODE});
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(32'd3, 32'd5, 0);

      for (int k = 0; k < 24; k++) begin
         randA = $urandom;
         randB = $urandom >> $urandom_range(0, 31);
         if (k % 6 == 5) randB = 32'd0;
         applyStimulus(randA, randB, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
